// File: rtl/tnoc_pkg.sv
// Shared NoC router types: VC mux FSM states, flit control markers and the
// wrap-around first-set-bit picker used by the VC arbiters.
package tnoc_pkg;

  localparam int unsigned TNOC_MAX_CHANNELS = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } vc_mux_state_e;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_ctrl_t;

  // Index of the first set bit at or after ptr, wrapping modulo channels; 0 if none.
  function automatic int unsigned tnoc_rr_pick(
    input logic [TNOC_MAX_CHANNELS-1:0] valid,
    input int unsigned                  ptr,
    input int unsigned                  channels
  );
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < TNOC_MAX_CHANNELS; i++) begin
      if (i < channels) begin
        idx = ptr + i;
        if (idx >= channels) idx = idx - channels;
        if (!found && valid[idx[4:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tnoc_rr_arbiter.sv
// Round-robin VC picker: scans from the pointer upward and moves the pointer
// past a VC once that VC's packet has completed.
module tnoc_rr_arbiter
  import tnoc_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int VC_WIDTH = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic [CHANNELS-1:0] i_request,
  input  logic                i_update,
  input  logic [VC_WIDTH-1:0] i_update_vc,
  output logic [VC_WIDTH-1:0] o_grant_vc
);

  logic [VC_WIDTH-1:0] rr_ptr;
  logic [VC_WIDTH-1:0] rr_next;

  assign o_grant_vc = VC_WIDTH'(tnoc_rr_pick(TNOC_MAX_CHANNELS'(i_request),
                                             32'(rr_ptr), CHANNELS));

  assign rr_next = (i_update_vc == VC_WIDTH'(CHANNELS - 1)) ? '0 : i_update_vc + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (i_clear) begin
      rr_ptr <= '0;
    end else if (i_update) begin
      rr_ptr <= rr_next;
    end
  end

endmodule

// File: rtl/tnoc_vc_packet_mux.sv
// Merges per-VC flit streams into one registered stream, holding a VC's grant
// for a whole packet. Define TNOC_VC_PACKET_MUX_FIXED_PRIORITY_EN for fixed priority.
module tnoc_vc_packet_mux
  import tnoc_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64,
  parameter int VC_WIDTH   = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear,
  input  logic [CHANNELS-1:0]            i_valid,
  output logic [CHANNELS-1:0]            o_ready,
  input  logic [CHANNELS-1:0]            i_head,
  input  logic [CHANNELS-1:0]            i_tail,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_head,
  output logic                           o_tail,
  output logic [FLIT_WIDTH-1:0]          o_flit,
  output logic [VC_WIDTH-1:0]            o_vc
);

  vc_mux_state_e       state_q;
  vc_mux_state_e       state_d;
  logic [VC_WIDTH-1:0] lock_vc;
  logic [VC_WIDTH-1:0] pick_vc_p0;
  logic [VC_WIDTH-1:0] sel_vc_p0;
  logic                open_p0;
  logic                accept_p0;
  logic                tail_done_p0;
  flit_ctrl_t          ctrl_p0;

`ifdef TNOC_VC_PACKET_MUX_FIXED_PRIORITY_EN
  assign pick_vc_p0 = VC_WIDTH'(tnoc_rr_pick(TNOC_MAX_CHANNELS'(i_valid), 0, CHANNELS));
`else
  tnoc_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .VC_WIDTH (VC_WIDTH)
  ) u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (i_clear),
    .i_request   (i_valid),
    .i_update    (tail_done_p0),
    .i_update_vc (sel_vc_p0),
    .o_grant_vc  (pick_vc_p0)
  );
`endif

  // Stage p0: select the source VC, decide acceptance and the next FSM state
  always_comb begin
    open_p0      = !o_valid || i_ready;
    sel_vc_p0    = (state_q == LOCKED) ? lock_vc : pick_vc_p0;
    accept_p0    = i_valid[sel_vc_p0] && open_p0 && !i_clear;
    ctrl_p0      = '{head: i_head[sel_vc_p0], tail: i_tail[sel_vc_p0]};
    tail_done_p0 = accept_p0 && ctrl_p0.tail;
    o_ready      = '0;
    state_d      = state_q;
    if (accept_p0) begin
      o_ready[sel_vc_p0] = 1'b1;
      state_d            = ctrl_p0.tail ? IDLE : LOCKED;
    end
    if (i_clear) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_vc <= '0;
    end else begin
      state_q <= state_d;
      if (accept_p0 && !ctrl_p0.tail) lock_vc <= sel_vc_p0;
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_head  <= 1'b0;
      o_tail  <= 1'b0;
      o_flit  <= '0;
      o_vc    <= '0;
    end else begin
      if (i_clear) begin
        o_valid <= 1'b0;
      end else if (accept_p0) begin
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (accept_p0) begin
        o_head <= ctrl_p0.head;
        o_tail <= ctrl_p0.tail;
        o_flit <= i_flit[sel_vc_p0*FLIT_WIDTH +: FLIT_WIDTH];
        o_vc   <= sel_vc_p0;
      end
    end
  end

endmodule

// File: tb/tb_tnoc_vc_packet_mux.sv
// Directed bench for tnoc_vc_packet_mux with two VCs and 16-bit flits.
module tb_tnoc_vc_packet_mux;

  localparam int CHANNELS   = 2;
  localparam int FLIT_WIDTH = 16;
  localparam int VC_WIDTH   = 1;

  logic                           clk = 1'b0;
  logic                           rst = 1'b0;
  logic                           i_clear = 1'b0;
  logic [CHANNELS-1:0]            i_valid = '0;
  logic [CHANNELS-1:0]            o_ready;
  logic [CHANNELS-1:0]            i_head = '0;
  logic [CHANNELS-1:0]            i_tail = '0;
  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit = '0;
  logic                           o_valid;
  logic                           i_ready = 1'b1;
  logic                           o_head;
  logic                           o_tail;
  logic [FLIT_WIDTH-1:0]          o_flit;
  logic [VC_WIDTH-1:0]            o_vc;

  int checks = 0;
  int errors = 0;

  tnoc_vc_packet_mux #(
    .CHANNELS   (CHANNELS),
    .FLIT_WIDTH (FLIT_WIDTH),
    .VC_WIDTH   (VC_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_head  (i_head),
    .i_tail  (i_tail),
    .i_flit  (i_flit),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_head  (o_head),
    .o_tail  (o_tail),
    .o_flit  (o_flit),
    .o_vc    (o_vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs then settle before checks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [1:0] h, input logic [1:0] t,
                     input logic [15:0] f0, input logic [15:0] f1);
    i_valid = v;
    i_head  = h;
    i_tail  = t;
    i_flit  = {f1, f0};
    #1;
  endtask

  initial begin
    logic [1:0] exp_rdy;

    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_flit",  64'(o_flit),  64'h0);
    chk("rst_vc",    64'(o_vc),    64'h0);
    chk("rst_ready", 64'(o_ready), 64'h0);
    step();
    step();
    rst = 1'b0;

    // VC0 three-flit packet
    drv(2'b01, 2'b01, 2'b00, 16'hA000, 16'h0);
    chk("p3_rdy0", 64'(o_ready), 64'h1);
    step();
    drv(2'b01, 2'b00, 2'b00, 16'hA001, 16'h0);
    chk("p3_rdy1", 64'(o_ready), 64'h1);
    chk("p3_flit0", 64'(o_flit), 64'hA000);
    chk("p3_head0", 64'(o_head), 64'h1);
    chk("p3_vc0",   64'(o_vc),   64'h0);
    chk("p3_val0",  64'(o_valid), 64'h1);
    step();
    drv(2'b01, 2'b00, 2'b01, 16'hA002, 16'h0);
    chk("p3_rdy2", 64'(o_ready), 64'h1);
    chk("p3_flit1", 64'(o_flit), 64'hA001);
    chk("p3_head1", 64'(o_head), 64'h0);
    chk("p3_tail1", 64'(o_tail), 64'h0);
    step();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    chk("p3_rdy3", 64'(o_ready), 64'h0);
    chk("p3_flit2", 64'(o_flit), 64'hA002);
    chk("p3_tail2", 64'(o_tail), 64'h1);
    chk("p3_val2",  64'(o_valid), 64'h1);
    step();
    chk("p3_drain", 64'(o_valid), 64'h0);

    // Clear with nothing pending returns the pointer to VC0
    i_clear = 1'b1;
    #1;
    chk("clr_rdy", 64'(o_ready), 64'h0);
    step();
    i_clear = 1'b0;

    // Two competing two-flit packets, no bubble between them
    drv(2'b11, 2'b11, 2'b00, 16'hB000, 16'hC000);
    chk("two_rdy0", 64'(o_ready), 64'h1);
    step();
    drv(2'b11, 2'b10, 2'b01, 16'hB001, 16'hC000);
    chk("two_rdy1", 64'(o_ready), 64'h1);
    chk("two_flit0", 64'(o_flit), 64'hB000);
    step();
    drv(2'b10, 2'b10, 2'b00, 16'h0, 16'hC000);
    chk("two_rdy2", 64'(o_ready), 64'h2);
    chk("two_flit1", 64'(o_flit), 64'hB001);
    chk("two_tail1", 64'(o_tail), 64'h1);
    step();
    drv(2'b10, 2'b00, 2'b10, 16'h0, 16'hC001);
    chk("two_rdy3", 64'(o_ready), 64'h2);
    chk("two_flit2", 64'(o_flit), 64'hC000);
    chk("two_vc2",   64'(o_vc),   64'h1);
    chk("two_val2",  64'(o_valid), 64'h1);
    step();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    chk("two_flit3", 64'(o_flit), 64'hC001);
    chk("two_vc3",   64'(o_vc),   64'h1);
    step();

    // VC1 mid-packet gap must not let VC0 in
    drv(2'b10, 2'b10, 2'b00, 16'h0, 16'hD000);
    chk("gap_rdy0", 64'(o_ready), 64'h2);
    step();
    drv(2'b01, 2'b01, 2'b01, 16'hE000, 16'h0);
    chk("gap_rdy1", 64'(o_ready), 64'h0);
    chk("gap_flit0", 64'(o_flit), 64'hD000);
    step();
    chk("gap_rdy2", 64'(o_ready), 64'h0);
    chk("gap_val2", 64'(o_valid), 64'h0);
    step();
    drv(2'b11, 2'b01, 2'b11, 16'hE000, 16'hD001);
    chk("gap_rdy3", 64'(o_ready), 64'h2);
    step();
    drv(2'b01, 2'b01, 2'b01, 16'hE000, 16'h0);
    chk("gap_rdy4", 64'(o_ready), 64'h1);
    chk("gap_flit3", 64'(o_flit), 64'hD001);
    step();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    chk("gap_flit4", 64'(o_flit), 64'hE000);
    chk("gap_vc4",   64'(o_vc),   64'h0);
    step();

    // Backpressure: register holds while i_ready is low
    drv(2'b01, 2'b01, 2'b01, 16'hF000, 16'h0);
    chk("bp_rdy0", 64'(o_ready), 64'h1);
    step();
    i_ready = 1'b0;
    drv(2'b01, 2'b01, 2'b01, 16'hF001, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_rdy",  64'(o_ready), 64'h0);
      chk("bp_hold_flit", 64'(o_flit),  64'hF000);
      chk("bp_hold_val",  64'(o_valid), 64'h1);
      step();
    end
    i_ready = 1'b1;
    #1;
    chk("bp_rel_rdy",  64'(o_ready), 64'h1);
    chk("bp_rel_flit", 64'(o_flit),  64'hF000);
    step();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    chk("bp_next_flit", 64'(o_flit),  64'hF001);
    chk("bp_next_val",  64'(o_valid), 64'h1);
    step();
    chk("bp_drain", 64'(o_valid), 64'h0);

    // Clear while locked on VC1 drops the lock and the in-flight flit
    drv(2'b10, 2'b10, 2'b00, 16'h0, 16'h1000);
    chk("clk_rdy0", 64'(o_ready), 64'h2);
    step();
    i_clear = 1'b1;
    drv(2'b11, 2'b01, 2'b01, 16'h2000, 16'h1001);
    chk("clk_rdy1", 64'(o_ready), 64'h0);
    step();
    i_clear = 1'b0;
    #1;
    chk("clk_val", 64'(o_valid), 64'h0);
    chk("clk_rdy2", 64'(o_ready), 64'h1);
    step();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    chk("clk_flit", 64'(o_flit), 64'h2000);
    chk("clk_vc",   64'(o_vc),   64'h0);
    step();

    // Single-flit packets on both VCs
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    drv(2'b11, 2'b11, 2'b11, 16'h3000, 16'h3001);
    for (int i = 0; i < 4; i++) begin
`ifdef TNOC_VC_PACKET_MUX_FIXED_PRIORITY_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("single_rdy", 64'(o_ready), 64'(exp_rdy));
      step();
      chk("single_vc", 64'(o_vc), 64'(exp_rdy[1]));
    end
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    step();

    // Reset mid-packet on VC1 drops the lock
    drv(2'b10, 2'b10, 2'b00, 16'h0, 16'h4000);
    chk("mrst_rdy0", 64'(o_ready), 64'h2);
    step();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    rst = 1'b1;
    #1;
    chk("mrst_val",  64'(o_valid), 64'h0);
    chk("mrst_flit", 64'(o_flit),  64'h0);
    step();
    rst = 1'b0;
    drv(2'b11, 2'b01, 2'b01, 16'h5000, 16'h4001);
    chk("mrst_rdy1", 64'(o_ready), 64'h1);
    step();
    chk("mrst_flit1", 64'(o_flit), 64'h5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnoc_vc_packet_mux.md
# tnoc_vc_packet_mux

Merges the per-virtual-channel flit streams leaving the router input FIFOs into one flit stream for the route/switch stage. A VC keeps its grant from the first flit of a packet through its tail flit, so flits of different packets never interleave. Arbitration between VCs is round-robin at packet boundaries. The output is registered and sustains full throughput under valid/ready.

## Interface
- CHANNELS, default 2: number of virtual channels; must be at least 2.
- FLIT_WIDTH, default 64: width of the flit payload.
- VC_WIDTH, default $clog2(CHANNELS): width of the VC index.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- i_clear  in  1  synchronous flush.
- i_valid  in  CHANNELS  per-VC flit valid, driven by the FIFOs.
- o_ready  out  CHANNELS  per-VC pop; at most one bit is high in a cycle.
- i_head  in  CHANNELS  per-VC head-flit marker.
- i_tail  in  CHANNELS  per-VC tail-flit marker.
- i_flit  in  CHANNELS*FLIT_WIDTH  per-VC payload; VC k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
- o_valid  out  1  merged flit valid.
- i_ready  in  1  downstream ready.
- o_head / o_tail  out  1 each  markers of the merged flit.
- o_flit  out  FLIT_WIDTH  merged payload.
- o_vc  out  VC_WIDTH  source VC of the merged flit.

## Operation
- A flit is accepted from VC k in a cycle when i_valid[k] and o_ready[k] are both high.
- Output register state: the register is "open" when o_valid is low or i_ready is high. o_ready is low on all VCs while the register is not open.
- FSM state IDLE:
  - The arbiter scans from rr_ptr upward, wrapping modulo CHANNELS, and picks the first k with i_valid[k].
  - It raises o_ready[k] if the register is open.
  - If the accepted flit has i_tail low, the FSM moves to LOCKED with lock_vc = k.
  - If i_tail is high (single-flit packet), the FSM stays in IDLE and rr_ptr becomes (k+1) mod CHANNELS.
- FSM state LOCKED:
  - Only lock_vc is eligible. o_ready[lock_vc] equals "register open". Valid on other VCs is ignored.
  - Accepting a flit with i_tail high returns the FSM to IDLE and sets rr_ptr to (lock_vc+1) mod CHANNELS.
  - A gap in i_valid[lock_vc] holds LOCKED indefinitely.
- The head marker does not influence arbitration; any flit accepted in IDLE starts a packet. A head flit arriving in LOCKED is forwarded unchanged. Upstream guarantees correct framing.
- Accepting a flit loads o_flit, o_head, o_tail and o_vc into the register and sets o_valid.
- When the register drains with no new acceptance, o_valid clears.
- i_clear high:
  - next cycle o_valid = 0, FSM = IDLE, rr_ptr = 0;
  - o_ready is forced low during the clear cycle;
  - the in-flight flit is discarded.
- rst high, asynchronously: o_valid = 0, FSM = IDLE, rr_ptr = 0, lock_vc = 0. The register data outputs o_flit, o_head, o_tail and o_vc also reset to 0.

## Timing
- Latency is 1 cycle: a flit accepted in cycle n appears on o_* in cycle n+1.
- Throughput is one flit per cycle when i_ready stays high. No bubble is inserted at packet boundaries: the tail of one packet and the head of the next, from any VC, can be accepted in consecutive cycles.
- o_ready is combinational from i_valid, i_ready, the FSM state, rr_ptr and i_clear. There is no combinational path from i_flit to any output.
- o_* remain stable while o_valid is high and i_ready is low.
- Reset applied mid-packet drops the lock. After reset, the next accepted flit is arbitrated from VC 0.

## Configuration
- TNOC_VC_PACKET_MUX_FIXED_PRIORITY_EN:
  - When defined, the IDLE scan always starts at VC 0 (lowest index wins) and rr_ptr is not implemented.
  - When undefined, round-robin operates as described above.
  - Packet locking is identical in both builds.

## Structure
- Shared package (tnoc_pkg) holds:
  - the vc_mux state typedef (enum IDLE, LOCKED);
  - a flit_ctrl struct {head, tail};
  - function tnoc_rr_pick(valid, ptr), which returns the index of the first set bit at or after ptr, wrapping.
- One sub-module is natural: tnoc_rr_arbiter (CHANNELS-wide round-robin pick with pointer update). It is bypassed under the fixed-priority macro.

## Test plan
- Reset, then VC0 sends a 3-flit packet with i_ready held high -> o_ready[0] is high for 3 consecutive cycles; o_valid is high in cycles 1–3 after the first acceptance; o_vc = 0; o_head on the first flit and o_tail on the third.
- VC0 and VC1 both hold 2-flit packets from the first cycle -> output order is VC0 f0, VC0 f1, VC1 f0, VC1 f1 with no idle cycle; o_ready[1] stays low until VC0's tail is accepted.
- VC1 starts a packet, then VC1 valid drops for 2 cycles mid-packet while VC0 is valid -> no VC0 flit is emitted until VC1's tail is accepted.
- i_ready held low for 4 cycles with a flit in the register -> o_flit is stable; all o_ready bits are low; no flit is lost or duplicated after i_ready rises.
- i_clear asserted while LOCKED on VC1 -> o_valid = 0 the next cycle; the next packet from VC0 is arbitrated normally (VC0 is granted before VC1).
- Fixed-priority build with VC0 and VC1 continuously sending single-flit packets -> only VC0 is granted; in the default build, grants alternate 0, 1, 0, 1.
